// File: rtl/ranger_patrol_array.sv
// ranger_patrol_array: enemy controller for NUM_RANGERS rangers. Each ranger
// patrols one axis around its home position, moving STEP px on every movement
// tick. It reverses at its span limit or at the screen bound, and it can be
// killed. Position readout is by index for the sprite renderer.
//
// Optional feature macro: RANGER_RESPAWN_EN. When defined, a dead ranger comes
// back to its home position after RESPAWN_TICKS movement ticks. When undefined,
// a dead ranger stays dead until rst.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   freeze     1 = hold all rangers and the tick divider
//   kill       1-cycle pulse: kill ranger kill_idx
//   kill_idx   index of the ranger to kill (>= NUM_RANGERS is ignored)
//   rangerNum  readout select
//   position   {hpos,vpos} of ranger rangerNum, one cycle later; 0 if dead or out of range
//   alive      per-ranger alive flags
//   all_dead   registered flag for alive == 0
module ranger_patrol_array #(
    parameter int unsigned NUM_RANGERS = 5,
    parameter int unsigned STEP        = 5,
    parameter int unsigned TICK_DIV    = 833333,
    parameter int unsigned SPAN        = 64,
    parameter int unsigned LEFT_BOUND  = 144,
    parameter int unsigned RIGHT_BOUND = 783,
    parameter int unsigned UP_BOUND    = 31,
    parameter int unsigned DOWN_BOUND  = 510,
    parameter logic [NUM_RANGERS*20-1:0] INIT_POS = {
        10'd200, 10'd240,   // ranger 4
        10'd760, 10'd400,   // ranger 3
        10'd464, 10'd60,    // ranger 2
        10'd656, 10'd127,   // ranger 1
        10'd368, 10'd127    // ranger 0
    },
    parameter logic [NUM_RANGERS-1:0] AXIS_MASK = 5'b10100
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   kill,
    input  logic [2:0]             kill_idx,
    input  logic [2:0]             rangerNum,
    output logic [19:0]            position,
    output logic [NUM_RANGERS-1:0] alive,
    output logic                   all_dead
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW    = 11;

    typedef enum logic [1:0] {FWD, REV, DEAD} state_t;

    state_t                 state_q [NUM_RANGERS];
    state_t                 state_d [NUM_RANGERS];
    logic [19:0]            pos_q   [NUM_RANGERS];
    logic [19:0]            pos_d   [NUM_RANGERS];
    logic [CW-1:0]          lo_c    [NUM_RANGERS];
    logic [CW-1:0]          hi_c    [NUM_RANGERS];
    logic [CW-1:0]          p_c     [NUM_RANGERS];
    logic [NUM_RANGERS-1:0] alive_d;
    logic [DIV_W-1:0]       div_q;
    logic                   tick_c;
    logic [19:0]            pos_sel_c;

`ifdef RANGER_RESPAWN_EN
    localparam int unsigned RESPAWN_TICKS = 180;
    localparam int unsigned RSP_W         = $clog2(RESPAWN_TICKS);

    logic [RSP_W-1:0] rsp_q [NUM_RANGERS];
    logic [RSP_W-1:0] rsp_d [NUM_RANGERS];
`endif

    // One-cycle movement tick at the last divider count; freeze masks it.
    assign tick_c = !freeze && (div_q == DIV_W'(TICK_DIV - 1));

    // Per-ranger patrol limits (elaboration constants) and the moving coordinate.
    for (genvar g = 0; g < NUM_RANGERS; g++) begin : g_lim
        localparam int unsigned HOME = AXIS_MASK[g] ? int'(INIT_POS[20*g +: 10])
                                                    : int'(INIT_POS[20*g+10 +: 10]);
        localparam int unsigned LO_B = AXIS_MASK[g] ? UP_BOUND : LEFT_BOUND;
        localparam int unsigned HI_B = AXIS_MASK[g] ? DOWN_BOUND : RIGHT_BOUND;
        // Subtraction guarded so a home near the edge cannot wrap below the bound.
        localparam int unsigned LO   = (HOME >= SPAN + LO_B) ? HOME - SPAN : LO_B;
        localparam int unsigned HI   = (HOME + SPAN <= HI_B) ? HOME + SPAN : HI_B;

        assign lo_c[g] = CW'(LO);
        assign hi_c[g] = CW'(HI);
        assign p_c[g]  = AXIS_MASK[g] ? {1'b0, pos_q[g][9:0]} : {1'b0, pos_q[g][19:10]};
    end

    // Next-state logic for every ranger FSM; kill wins over a same-cycle tick.
    always_comb begin
        logic [CW-1:0] nxt_p;
        nxt_p = '0;
        for (int i = 0; i < NUM_RANGERS; i++) begin
            state_d[i] = state_q[i];
            pos_d[i]   = pos_q[i];
            alive_d[i] = alive[i];
`ifdef RANGER_RESPAWN_EN
            rsp_d[i]   = rsp_q[i];
`endif
            if (kill && (kill_idx == 3'(i))) begin
                state_d[i] = DEAD;
                alive_d[i] = 1'b0;
`ifdef RANGER_RESPAWN_EN
                rsp_d[i]   = '0;
`endif
            end else if (tick_c) begin
                nxt_p = p_c[i];
                case (state_q[i])
                    FWD: begin
                        if (p_c[i] + CW'(STEP) >= hi_c[i]) begin
                            nxt_p      = hi_c[i];
                            state_d[i] = REV;
                        end else begin
                            nxt_p = p_c[i] + CW'(STEP);
                        end
                    end
                    REV: begin
                        // Compare as p <= lo + STEP so p - STEP never underflows.
                        if (p_c[i] <= lo_c[i] + CW'(STEP)) begin
                            nxt_p      = lo_c[i];
                            state_d[i] = FWD;
                        end else begin
                            nxt_p = p_c[i] - CW'(STEP);
                        end
                    end
                    default: ;
                endcase
                if (AXIS_MASK[i]) begin
                    pos_d[i][9:0] = 10'(nxt_p);
                end else begin
                    pos_d[i][19:10] = 10'(nxt_p);
                end
`ifdef RANGER_RESPAWN_EN
                if (state_q[i] == DEAD) begin
                    if (rsp_q[i] == RSP_W'(RESPAWN_TICKS - 1)) begin
                        state_d[i] = FWD;
                        alive_d[i] = 1'b1;
                        pos_d[i]   = INIT_POS[20*i +: 20];
                        rsp_d[i]   = '0;
                    end else begin
                        rsp_d[i] = rsp_q[i] + RSP_W'(1);
                    end
                end
`endif
            end
        end
    end

    // Readout mux: live ranger selected by rangerNum, zero otherwise.
    always_comb begin
        pos_sel_c = '0;
        for (int i = 0; i < NUM_RANGERS; i++) begin
            if ((rangerNum == 3'(i)) && alive[i]) begin
                pos_sel_c = pos_q[i];
            end
        end
    end

    // State, divider and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            position <= '0;
            alive    <= '1;
            all_dead <= 1'b0;
            for (int i = 0; i < NUM_RANGERS; i++) begin
                state_q[i] <= FWD;
                pos_q[i]   <= INIT_POS[20*i +: 20];
`ifdef RANGER_RESPAWN_EN
                rsp_q[i]   <= '0;
`endif
            end
        end else begin
            if (!freeze) begin
                div_q <= tick_c ? '0 : div_q + DIV_W'(1);
            end
            for (int i = 0; i < NUM_RANGERS; i++) begin
                state_q[i] <= state_d[i];
                pos_q[i]   <= pos_d[i];
`ifdef RANGER_RESPAWN_EN
                rsp_q[i]   <= rsp_d[i];
`endif
            end
            alive    <= alive_d;
            position <= pos_sel_c;
            all_dead <= (alive == '0);
        end
    end

endmodule

// File: tb/tb_ranger_patrol_array.sv
// Bench for ranger_patrol_array with TICK_DIV=4: directed vector table plus
// randomized traffic checked every cycle against a behavioural model.
module tb_ranger_patrol_array;

    localparam int NR   = 5;
    localparam int TDIV = 4;
    localparam int STEP = 5;
    localparam int SPAN = 64;
`ifdef RANGER_RESPAWN_EN
    localparam int RESPAWN = 180;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          freeze;
    logic          kill;
    logic [2:0]    kill_idx;
    logic [2:0]    rangerNum;
    logic [19:0]   position;
    logic [NR-1:0] alive;
    logic          all_dead;

    ranger_patrol_array #(.TICK_DIV(TDIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .freeze    (freeze),
        .kill      (kill),
        .kill_idx  (kill_idx),
        .rangerNum (rangerNum),
        .position  (position),
        .alive     (alive),
        .all_dead  (all_dead)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Home positions and patrol axis of the default configuration.
    int home_h [NR] = '{368, 656, 464, 760, 200};
    int home_v [NR] = '{127, 127, 60, 400, 240};
    bit vert   [NR] = '{0, 0, 1, 0, 1};
    int lo [NR];
    int hi [NR];

    // Behavioural model state.
    int          m_div;
    int          m_p    [NR];
    int          m_dir  [NR];
    int          m_rcnt [NR];
    logic [NR-1:0] m_alive;
    logic [19:0] m_position;
    logic        m_all_dead;

    typedef struct {
        bit         rst;
        bit         frz;
        bit         kil;
        logic [2:0] kidx;
        logic [2:0] sel;
        int         ncyc;
        bit         chk_pos;
        logic [19:0] pos;
        logic [4:0] alv;
        bit         ad;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit r, bit f, bit k, int ki, int s, int n, bit cp,
                                int ph, int pv, logic [4:0] a, bit d);
        vec_t v;
        v.rst = r; v.frz = f; v.kil = k; v.kidx = 3'(ki); v.sel = 3'(s);
        v.ncyc = n; v.chk_pos = cp; v.pos = {10'(ph), 10'(pv)}; v.alv = a; v.ad = d;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [19:0] coord(int i);
        if (vert[i]) return {10'(home_h[i]), 10'(m_p[i])};
        return {10'(m_p[i]), 10'(home_v[i])};
    endfunction

    function automatic void model_reset();
        m_div = 0;
        m_alive = '1;
        m_position = '0;
        m_all_dead = 1'b0;
        for (int i = 0; i < NR; i++) begin
            m_p[i]    = vert[i] ? home_v[i] : home_h[i];
            m_dir[i]  = 1;
            m_rcnt[i] = 0;
        end
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    function automatic void model_edge();
        logic [19:0] nxt_pos;
        logic        nxt_ad;
        bit          tick;
        int          sel;
        if (rst) begin
            model_reset();
            return;
        end
        sel = int'(rangerNum);
        nxt_pos = '0;
        if (sel < NR && m_alive[sel]) nxt_pos = coord(sel);
        nxt_ad = (m_alive == '0);
        tick = !freeze && (m_div == TDIV - 1);
        if (!freeze) m_div = tick ? 0 : m_div + 1;
        for (int i = 0; i < NR; i++) begin
            if (kill && int'(kill_idx) == i) begin
                m_alive[i] = 1'b0;
                m_rcnt[i]  = 0;
            end else if (tick) begin
                if (m_alive[i]) begin
                    if (m_dir[i] > 0) begin
                        if (m_p[i] + STEP >= hi[i]) begin m_p[i] = hi[i]; m_dir[i] = -1; end
                        else m_p[i] = m_p[i] + STEP;
                    end else begin
                        if (m_p[i] - STEP <= lo[i]) begin m_p[i] = lo[i]; m_dir[i] = 1; end
                        else m_p[i] = m_p[i] - STEP;
                    end
                end
`ifdef RANGER_RESPAWN_EN
                else begin
                    m_rcnt[i]++;
                    if (m_rcnt[i] == RESPAWN) begin
                        m_alive[i] = 1'b1;
                        m_p[i]     = vert[i] ? home_v[i] : home_h[i];
                        m_dir[i]   = 1;
                        m_rcnt[i]  = 0;
                    end
                end
`endif
            end
        end
        m_position = nxt_pos;
        m_all_dead = nxt_ad;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_position", 32'(position), 32'(m_position));
        chk("model_alive", 32'(alive), 32'(m_alive));
        chk("model_all_dead", 32'(all_dead), 32'(m_all_dead));
    endtask

    initial begin
        int h;
        rst = 1'b1; freeze = 1'b0; kill = 1'b0; kill_idx = '0; rangerNum = '0;
        for (int i = 0; i < NR; i++) begin
            if (vert[i]) begin
                lo[i] = (home_v[i] - SPAN > 31)  ? home_v[i] - SPAN : 31;
                hi[i] = (home_v[i] + SPAN < 510) ? home_v[i] + SPAN : 510;
            end else begin
                lo[i] = (home_h[i] - SPAN > 144) ? home_h[i] - SPAN : 144;
                hi[i] = (home_h[i] + SPAN < 783) ? home_h[i] + SPAN : 783;
            end
        end
        model_reset();

        // Reset and ranger 0 horizontal trajectory, clamp at 432.
        add(1, 0, 0, 0, 0, 2, 1, 0, 0, 5'h1F, 0);
        add(0, 0, 0, 0, 0, 1, 1, 368, 127, 5'h1F, 0);
        for (int k = 1; k <= 14; k++) begin
            h = (k <= 12) ? 368 + 5 * k : ((k == 13) ? 432 : 427);
            add(0, 0, 0, 0, 0, 4, 1, h, 127, 5'h1F, 0);
        end
        // Ranger 4 vertical: up to 304, down to 176, back up.
        add(1, 0, 0, 0, 4, 1, 1, 0, 0, 5'h1F, 0);
        add(0, 0, 0, 0, 4, 1, 1, 200, 240, 5'h1F, 0);
        add(0, 0, 0, 0, 4, 52, 1, 200, 304, 5'h1F, 0);
        add(0, 0, 0, 0, 4, 4, 1, 200, 299, 5'h1F, 0);
        add(0, 0, 0, 0, 4, 100, 1, 200, 176, 5'h1F, 0);
        add(0, 0, 0, 0, 4, 4, 1, 200, 181, 5'h1F, 0);
        // Freeze 20 cycles, then the tick resumes after the remaining count.
        add(0, 1, 0, 0, 4, 20, 1, 200, 181, 5'h1F, 0);
        add(0, 0, 0, 0, 4, 2, 1, 200, 181, 5'h1F, 0);
        add(0, 0, 0, 0, 4, 1, 1, 200, 181, 5'h1F, 0);
        add(0, 0, 0, 0, 4, 1, 1, 200, 186, 5'h1F, 0);
        // Kill ranger 2 on a tick cycle, ignored index, then kill everyone.
        add(0, 0, 0, 0, 2, 2, 0, 0, 0, 5'h1F, 0);
        add(0, 0, 1, 2, 2, 1, 0, 0, 0, 5'b11011, 0);
        add(0, 0, 0, 0, 2, 1, 1, 0, 0, 5'b11011, 0);
        add(0, 0, 1, 6, 2, 2, 1, 0, 0, 5'b11011, 0);
        add(0, 0, 1, 0, 2, 1, 1, 0, 0, 5'b11010, 0);
        add(0, 0, 1, 1, 2, 1, 1, 0, 0, 5'b11000, 0);
        add(0, 0, 1, 2, 2, 1, 1, 0, 0, 5'b11000, 0);
        add(0, 0, 1, 3, 2, 1, 1, 0, 0, 5'b10000, 0);
        add(0, 0, 1, 4, 2, 1, 1, 0, 0, 5'b00000, 0);
        add(0, 0, 0, 0, 5, 1, 1, 0, 0, 5'b00000, 1);
`ifdef RANGER_RESPAWN_EN
        // Ranger 1 returns home after 180 ticks; rst mid-countdown restores all.
        add(1, 0, 0, 0, 1, 1, 1, 0, 0, 5'h1F, 0);
        add(0, 0, 1, 1, 1, 716, 1, 0, 0, 5'b11101, 0);
        add(0, 0, 0, 0, 1, 4, 1, 0, 0, 5'h1F, 0);
        add(0, 0, 0, 0, 1, 1, 1, 656, 127, 5'h1F, 0);
        add(1, 0, 0, 0, 1, 1, 1, 0, 0, 5'h1F, 0);
        add(0, 0, 1, 1, 1, 360, 1, 0, 0, 5'b11101, 0);
        add(1, 0, 0, 0, 1, 1, 1, 0, 0, 5'h1F, 0);
        add(0, 0, 0, 0, 1, 1, 1, 656, 127, 5'h1F, 0);
`endif

        foreach (vecs[r]) begin
            rst = vecs[r].rst; freeze = vecs[r].frz; kill = vecs[r].kil;
            kill_idx = vecs[r].kidx; rangerNum = vecs[r].sel;
            for (int c = 0; c < vecs[r].ncyc; c++) begin
                cycle();
                kill = 1'b0;
            end
            if (vecs[r].chk_pos)
                chk($sformatf("vec%0d_position", r), 32'(position), 32'(vecs[r].pos));
            chk($sformatf("vec%0d_alive", r), 32'(alive), 32'(vecs[r].alv));
            chk($sformatf("vec%0d_all_dead", r), 32'(all_dead), 32'(vecs[r].ad));
        end

        // Randomized traffic against the model.
        rst = 1'b1; kill = 1'b0; freeze = 1'b0;
        cycle();
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 299) == 0);
            freeze    = ($urandom_range(0, 7) == 0);
            kill      = ($urandom_range(0, 63) == 0);
            kill_idx  = 3'($urandom_range(0, 7));
            rangerNum = 3'($urandom_range(0, 7));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
